// File: rtl/retire_rat_pkg.sv
// Shared types for the retirement RAT: physical tag type, commit lane width
// and the per-lane commit packet.
package retire_rat_pkg;

    localparam int SS_FACTOR          = 2;
    localparam int SS_FACTOR_BITS     = $clog2(SS_FACTOR);
    localparam int NUM_PHYS_REGS_BITS = 6;
    localparam int PREG_BITS          = NUM_PHYS_REGS_BITS;
    localparam int NUM_ARCH           = 32;
    localparam int ARCH_BITS          = 5;

    typedef logic [PREG_BITS-1:0] phys_reg;
    typedef logic [ARCH_BITS-1:0] arch_reg;

    typedef struct packed {
        logic    valid;
        logic    regf_we;
        arch_reg rd_arch;
        phys_reg rd_phys;
    } commit_pkt_t;

    // A lane touches the map only if it really writes a nonzero destination.
    function automatic logic lane_effective(input commit_pkt_t p);
        return p.valid && p.regf_we && (p.rd_arch != '0);
    endfunction

endpackage

// File: rtl/retire_rat_free_compact.sv
// Packs the tags of the set bits of a valid mask towards index 0 and counts
// them; unused output slots are zero.
module free_compact #(
    parameter int N  = 2,
    parameter int W  = 6,
    parameter int CW = $clog2(N) + 1
) (
    input  logic [N-1:0]         valid_i,
    input  logic [N-1:0][W-1:0]  tags_i,
    output logic [N-1:0][W-1:0]  packed_o,
    output logic [CW-1:0]        count_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] n;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        packed_o = '0;
        n        = '0;
        for (int k = 0; k < N; k++) begin
            if (valid_i[k]) begin
                packed_o[n[IW-1:0]] = tags_i[k];
                n                   = n + 1'b1;
            end
        end
        count_o = n;
    end

endmodule

// File: rtl/retire_rat.sv
// Retirement register alias table: installs committed arch->phys mappings and
// returns the displaced tags to the free list as a registered, compacted vector.
module retire_rat
    import retire_rat_pkg::*;
#(
    parameter int SS      = SS_FACTOR,
    parameter int SS_BITS = $clog2(SS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [SS-1:0]                        commit_valid,
    input  logic [SS-1:0]                        commit_regf_we,
    input  logic [SS-1:0][ARCH_BITS-1:0]         commit_rd_arch,
    input  logic [SS-1:0][PREG_BITS-1:0]         commit_rd_phys,
    output logic [SS-1:0][PREG_BITS-1:0]         freed_register,
    output logic [SS_BITS:0]                     rrf_push,
    output logic [NUM_ARCH-1:0][PREG_BITS-1:0]   rrat_map
);

    commit_pkt_t [SS-1:0]          pkt;
    logic        [SS-1:0]          eff;
    phys_reg     [SS-1:0]          old_tag;
    phys_reg     [NUM_ARCH-1:0]    map_q, map_d;
    phys_reg     [SS-1:0]          freed_d, freed_q;
    logic        [SS_BITS:0]       push_d, push_q;

    always_comb begin
        for (int k = 0; k < SS; k++) begin
            pkt[k].valid   = commit_valid[k];
            pkt[k].regf_we = commit_regf_we[k];
            pkt[k].rd_arch = commit_rd_arch[k];
            pkt[k].rd_phys = commit_rd_phys[k];
            eff[k]         = lane_effective(pkt[k]);
        end
    end

    // A younger lane sees the tag installed by the newest older lane to the same rd.
    always_comb begin
        for (int k = 0; k < SS; k++) begin
            old_tag[k] = map_q[pkt[k].rd_arch];
            for (int j = 0; j < SS; j++) begin
                if (j < k && eff[j] && pkt[j].rd_arch == pkt[k].rd_arch) begin
                    old_tag[k] = pkt[j].rd_phys;
                end
            end
        end
    end

    // NOTE: blocking assignments here let the highest lane overwrite lower ones.
    always_comb begin
        map_d = map_q;
        for (int k = 0; k < SS; k++) begin
            if (eff[k]) begin
                map_d[pkt[k].rd_arch] = pkt[k].rd_phys;
            end
        end
    end

    free_compact #(
        .N  (SS),
        .W  (PREG_BITS),
        .CW (SS_BITS + 1)
    ) u_compact (
        .valid_i  (eff),
        .tags_i   (old_tag),
        .packed_o (freed_d),
        .count_o  (push_d)
    );

    // NOTE: the map is reset to identity, so it is built from flops, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                map_q[i] <= phys_reg'(i);
            end
            freed_q <= '0;
            push_q  <= '0;
        end else begin
            map_q   <= map_d;
            freed_q <= freed_d;
            push_q  <= push_d;
        end
    end

    assign rrat_map       = map_q;
    assign freed_register = freed_q;
    assign rrf_push       = push_q;

    for (genvar k = 1; k < SS; k++) begin : g_order
        a_contiguous_valid: assert property (
            @(posedge clk) disable iff (rst) commit_valid[k] |-> commit_valid[k-1]
        );
    end

endmodule

// File: tb/tb_retire_rat.sv
// Self-checking bench for retire_rat: directed literal cases, then a long
// randomized commit stream against a sequential lane-by-lane reference model.
module tb_retire_rat;
    import retire_rat_pkg::*;

    localparam int SS = SS_FACTOR;
    localparam int SB = $clog2(SS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [SS-1:0]                 commit_valid;
    logic [SS-1:0]                 commit_regf_we;
    logic [SS-1:0][4:0]            commit_rd_arch;
    logic [SS-1:0][PREG_BITS-1:0]  commit_rd_phys;
    logic [SS-1:0][PREG_BITS-1:0]  freed_register;
    logic [SB:0]                   rrf_push;
    logic [31:0][PREG_BITS-1:0]    rrat_map;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    int exp_map[32];
    int exp_freed[SS];
    int exp_push;
    int free_q[$];

    always #5 clk = ~clk;

    retire_rat dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_regf_we (commit_regf_we),
        .commit_rd_arch (commit_rd_arch),
        .commit_rd_phys (commit_rd_phys),
        .freed_register (freed_register),
        .rrf_push       (rrf_push),
        .rrat_map       (rrat_map)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) exp_map[i] = i;
        for (int k = 0; k < SS; k++) exp_freed[k] = 0;
        exp_push = 0;
        free_q.delete();
        for (int t = 32; t < 64; t++) free_q.push_back(t);
    endtask

    // Commits are retired one lane at a time in program order.
    task automatic model_step();
        int rd;
        for (int k = 0; k < SS; k++) exp_freed[k] = 0;
        exp_push = 0;
        for (int k = 0; k < SS; k++) begin
            rd = int'(commit_rd_arch[k]);
            if (commit_valid[k] && commit_regf_we[k] && rd != 0) begin
                exp_freed[exp_push] = exp_map[rd];
                free_q.push_back(exp_map[rd]);
                exp_map[rd] = int'(commit_rd_phys[k]);
                exp_push++;
            end
        end
    endtask

    task automatic take(input int tag);
        int idx;
        idx = -1;
        for (int i = 0; i < free_q.size(); i++) if (idx < 0 && free_q[i] == tag) idx = i;
        if (idx >= 0) free_q.delete(idx);
    endtask

    task automatic clear_inputs();
        commit_valid   = '0;
        commit_regf_we = '0;
        commit_rd_arch = '0;
        commit_rd_phys = '0;
    endtask

    task automatic set_lane(input int k, input bit v, input bit we, input int rd, input int ph);
        commit_valid[k]   = v;
        commit_regf_we[k] = we;
        commit_rd_arch[k] = 5'(rd);
        commit_rd_phys[k] = PREG_BITS'(ph);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        clear_inputs();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_push"}, rrf_push, 0);
        for (int k = 0; k < SS; k++) check($sformatf("%s_freed%0d", tag, k), freed_register[k], 0);
        for (int i = 0; i < 32; i++) check($sformatf("%s_map%0d", tag, i), rrat_map[i], i);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            bit [63:0] seen;
            bit        dup;
            int        t;
            check("rrf_push", rrf_push, exp_push);
            for (int k = 0; k < SS; k++)
                check($sformatf("freed[%0d]", k), freed_register[k], exp_freed[k]);
            for (int i = 0; i < 32; i++)
                check($sformatf("map[%0d]", i), rrat_map[i], exp_map[i]);
            seen = '0;
            dup  = 1'b0;
            for (int i = 1; i < 32; i++) begin
                t = int'(rrat_map[i]);
                if (t == 0 || seen[t]) dup = 1'b1;
                seen[t] = 1'b1;
            end
            for (int i = 0; i < free_q.size(); i++) begin
                t = free_q[i];
                if (t == 0 || seen[t]) dup = 1'b1;
                seen[t] = 1'b1;
            end
            check("tag_unique", dup, 0);
        end
    end

    initial begin
        int commits;
        int iter;
        int n;
        int rd;
        int rd0;
        int ph;
        bit we;

        clear_inputs();
        model_reset();
        rst = 1'b1;
        #12;
        check_reset_state("reset");
        cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("idle_push", rrf_push, 0);

        // Single commit on lane 0.
        set_lane(0, 1, 1, 5, 40); take(40);
        tick();
        @(negedge clk);
        check("single_freed0", freed_register[0], 5);
        check("single_push", rrf_push, 1);
        check("single_map5", rrat_map[5], 40);
        tick();
        @(negedge clk);
        check("single_push_drop", rrf_push, 0);

        // Two lanes, different destinations.
        set_lane(0, 1, 1, 3, 33); take(33);
        set_lane(1, 1, 1, 7, 34); take(34);
        tick();
        @(negedge clk);
        check("two_freed0", freed_register[0], 3);
        check("two_freed1", freed_register[1], 7);
        check("two_push", rrf_push, 2);

        // Same destination on both lanes: lane 1 frees lane 0's new tag.
        set_lane(0, 1, 1, 9, 41); take(41);
        set_lane(1, 1, 1, 9, 42); take(42);
        tick();
        @(negedge clk);
        check("coll_freed0", freed_register[0], 9);
        check("coll_freed1", freed_register[1], 41);
        check("coll_push", rrf_push, 2);
        check("coll_map9", rrat_map[9], 42);

        // x0 write on lane 0 is dropped; lane 1 compacts into slot 0.
        set_lane(0, 1, 1, 0, 43);
        set_lane(1, 1, 1, 4, 50); take(50);
        tick();
        @(negedge clk);
        check("x0_freed0", freed_register[0], 4);
        check("x0_freed1", freed_register[1], 0);
        check("x0_push", rrf_push, 1);
        check("x0_map0", rrat_map[0], 0);
        check("x0_map4", rrat_map[4], 50);

        // Valid commit without a register write frees nothing.
        set_lane(0, 1, 0, 6, 44);
        tick();
        @(negedge clk);
        check("nowe_push", rrf_push, 0);
        check("nowe_map6", rrat_map[6], 6);

        commits = 0;
        iter    = 0;
        while (commits < 10000) begin
            n   = $urandom_range(0, SS);
            rd0 = 0;
            for (int k = 0; k < n; k++) begin
                we = ($urandom % 8) != 0;
                rd = ($urandom % 4 == 0) ? int'($urandom % 4) : int'($urandom % 32);
                if (k == 1 && ($urandom % 4) == 0) rd = rd0;
                if (k == 0) rd0 = rd;
                if (we && rd != 0) ph = free_q.pop_front();
                else ph = int'($urandom % 64);
                set_lane(k, 1, we, rd, ph);
            end
            commits += n;
            if (iter == 3000) begin
                #2;
                rst = 1'b1;
                model_reset();
                clear_inputs();
                #1;
                check_reset_state("midrst");
                @(negedge clk);
                rst = 1'b0;
                tick();
                @(negedge clk);
                check("post_rst_push", rrf_push, 0);
            end else begin
                tick();
            end
            iter++;
        end
        repeat (3) tick();
        @(negedge clk);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/retire_rat.md
Name: retire_rat

Overview:
- Retirement register alias table: holds the committed arch→phys mapping for all 32 architectural registers.
- Sits between ROB commit and the free list.
- Each cycle it accepts up to SS in-order committing instructions and installs their new physical destinations. It returns the displaced physical registers to the free list as a compacted push vector with a count.
- Exports the full committed map so the front-end RAT can restore it on mispredict.

Parameters:
- SS, SS_FACTOR (2): commit lanes per cycle.
- SS_BITS, SS_FACTOR_BITS ($clog2(SS)): lane index width; the count width is SS_BITS+1.
- PREG_BITS, NUM_PHYS_REGS_BITS (6): physical register tag width.
- NUM_ARCH (32): architectural register count, fixed.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- commit_valid  in  [SS]  lane k commits this cycle.
- commit_regf_we  in  [SS]  lane k writes a destination register.
- commit_rd_arch  in  [SS] x 5  architectural destination of lane k.
- commit_rd_phys  in  [SS] x PREG_BITS  physical tag allocated to lane k at rename.
- freed_register  out  [SS] x PREG_BITS  displaced tags, compacted from index 0; feeds the free list `freed_register`.
- rrf_push  out  SS_BITS+1  number of valid entries in freed_register; feeds the free list `rrf_push`.
- rrat_map  out  [32] x PREG_BITS  committed mapping, driven directly from state.

Behaviour:
- Reset (async, rst=1):
  - map[i] = i for i = 0..31.
  - rrf_push = 0.
  - freed_register[*] = 0.
  - Reset takes effect mid-commit; nothing from the in-flight cycle survives.
- Lane qualification: lane k is effective iff commit_valid[k] && commit_regf_we[k] && commit_rd_arch[k] != 0.
  - Non-effective lanes never touch the map and never free a tag.
  - x0 map entry stays 0 forever.
- Lane ordering:
  - Lanes are in program order; lane 0 is oldest.
  - commit_valid must be contiguous from lane 0. A simulation assertion fires if lane k is valid while lane k-1 is invalid.
- Displaced tag, combinational over lanes in order:
  - For lane k, old_k is the newest value of map[rd_k] seen by lane k.
  - That is commit_rd_phys[j] of the highest effective j<k with rd_j == rd_k; otherwise the current map[rd_k].
  - A same-cycle older lane writing the same rd therefore frees its own new tag, not the stale map entry.
- Map update at posedge: map[rd_k] <= commit_rd_phys[k] for each effective lane. On an rd collision the highest lane wins.
- Compaction:
  - old_k for the effective lanes is packed into freed_register[0..n-1] in lane order.
  - n = number of effective lanes.
  - Unused slots hold 0.
- Latency:
  - freed_register and rrf_push are registered, appearing 1 cycle after commit.
  - rrf_push returns to 0 in the next cycle unless there are new commits.
  - rrat_map reflects a commit on the cycle after the edge.
- Mispredict:
  - No dedicated input. The ROB commits the mispredicting branch and stops.
  - The free list sees the registered push in the same cycle it recovers, and rrat_map is already up to date for the RAT copy.
- Invariant: at all times the 31 nonzero map entries plus the free list hold distinct tags. A bench scoreboard checks this.

Decomposition:
- rv32i_types additions:
  - phys_reg typedef of width PREG_BITS.
  - SS_FACTOR and SS_FACTOR_BITS.
  - A commit_pkt_t struct {valid, regf_we, rd_arch, rd_phys}, which may replace the four commit arrays.
- Sub-module free_compact (optional, combinational): takes a [SS] valid mask and [SS] tags, and returns packed tags plus a count. It is reusable by the ROB.

Test Plan:
- Reset → rrat_map[i]=i for all i, rrf_push=0; release rst and idle 5 cycles → still 0.
- Single commit, lane 0: rd=5, phys=40 → next cycle freed_register[0]=5, rrf_push=1, map[5]=40; cycle after, rrf_push=0.
- Two lanes, different rd: lane 0 rd=3/p33, lane 1 rd=7/p34 → freed={3,7}, rrf_push=2.
- Same-rd collision: lane 0 rd=9/p41, lane 1 rd=9/p42 → freed={9,41}, rrf_push=2, map[9]=42.
- Compaction and x0: lane 0 rd=0 with we=1, lane 1 rd=4/p50 → freed[0]=4, rrf_push=1, map[0]=0; also a lane with regf_we=0 → no free.
- Async reset mid-stream: assert rst between clock edges during back-to-back commits → outputs reset immediately, no stale push after release. Random 10k-commit run with the scoreboard checking tag uniqueness.
